mem_bus_arbiter: RTL and testbench

- Shares the single virtual memory bus (data/address/write-enable/data-out, covering BRAM plus the memory-mapped IO window) between two requesters.
- Port A is the CPU data port; port B is the program loader/DMA.
- A round-robin FSM sequences one transaction at a time through a two-phase ISSUE/DONE cycle, matching the one-cycle registered BRAM read latency.
- An optional lock lets one requester keep the bus for a bounded run of back-to-back transactions.

---
 rtl/mem_bus_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
// mem_bus_arbiter
// Shares one registered-read memory bus (BRAM plus memory-mapped IO window)
// between two requesters: port A (CPU data port) and port B (loader/DMA).
// Each transaction walks IDLE -> ISSUE -> DONE, one cycle per state, which
// lines up with the one-cycle registered read latency of the BRAM.
// Ties are broken round-robin. A requester may set its lock bit to keep the
// bus for up to LOCK_MAX consecutive transactions.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   a_*/b_*             requester ports: req, we, lock, addr, wdata in;
//                       ack (one-cycle pulse), rdata (valid with ack) out
//   mem_addr/wdata/wen  registered bus outputs, mem_rdata bus read data in
//   mem_rst             active-high bus reset, combinational ~reset
//   busy                high while a transaction is in ISSUE or DONE
//
// Optional build macro MEM_ARB_STATS_EN adds saturating 16-bit per-port
// grant counters a_grant_cnt / b_grant_cnt.
module mem_bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  output logic              mem_rst,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       a_grant_cnt,
  output logic [15:0]       b_grant_cnt
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_A    = 2'd1;
  localparam logic [1:0] OWN_B    = 2'd2;

  // A lock may be extended only while the run is shorter than LOCK_MAX.
  localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX - 1);

  logic [1:0]        state_r;
  logic [1:0]        owner_r;
  logic [3:0]        lock_cnt_r;
  logic              last_b_r;   // 1: port B completed the last transaction
  logic              gnt_b_r;    // 1: current transaction belongs to port B
  logic              we_r;
  logic              lock_r;
  logic              busy_r;
  logic              a_ack_r;
  logic              b_ack_r;
  logic [DATA_W-1:0] a_rdata_r;
  logic [DATA_W-1:0] b_rdata_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              mem_wen_r;

  logic              owner_hold_s;
  logic              grant_vld_s;
  logic              grant_b_s;
  logic              sel_we_s;
  logic              sel_lock_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  // Grant selection: a live lock wins, otherwise single request, otherwise round-robin.
  always_comb begin
    owner_hold_s = ((owner_r == OWN_A) && a_req) || ((owner_r == OWN_B) && b_req);
    grant_vld_s  = 1'b0;
    grant_b_s    = 1'b0;
    if (owner_hold_s) begin
      grant_vld_s = 1'b1;
      grant_b_s   = (owner_r == OWN_B);
    end else if (a_req && b_req) begin
      grant_vld_s = 1'b1;
      grant_b_s   = ~last_b_r;
    end else if (a_req) begin
      grant_vld_s = 1'b1;
      grant_b_s   = 1'b0;
    end else if (b_req) begin
      grant_vld_s = 1'b1;
      grant_b_s   = 1'b1;
    end else begin
      grant_vld_s = 1'b0;
      grant_b_s   = 1'b0;
    end
  end

  // Request fields of the port being granted.
  always_comb begin
    if (grant_b_s) begin
      sel_we_s    = b_we;
      sel_lock_s  = b_lock;
      sel_addr_s  = b_addr;
      sel_wdata_s = b_wdata;
    end else begin
      sel_we_s    = a_we;
      sel_lock_s  = a_lock;
      sel_addr_s  = a_addr;
      sel_wdata_s = a_wdata;
    end
  end

  // Transaction sequencer, bus registers, acks, read data and lock bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      owner_r     <= OWN_NONE;
      lock_cnt_r  <= 4'd0;
      last_b_r    <= 1'b1;
      gnt_b_r     <= 1'b0;
      we_r        <= 1'b0;
      lock_r      <= 1'b0;
      busy_r      <= 1'b0;
      a_ack_r     <= 1'b0;
      b_ack_r     <= 1'b0;
      a_rdata_r   <= '0;
      b_rdata_r   <= '0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_wen_r   <= 1'b0;
    end else begin
      a_ack_r   <= 1'b0;
      b_ack_r   <= 1'b0;
      mem_wen_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // An owner that dropped its request gives the lock up right away.
          if (!owner_hold_s) begin
            owner_r    <= OWN_NONE;
            lock_cnt_r <= 4'd0;
          end
          if (grant_vld_s) begin
            state_r     <= ST_ISSUE;
            busy_r      <= 1'b1;
            gnt_b_r     <= grant_b_s;
            we_r        <= sel_we_s;
            lock_r      <= sel_lock_s;
            mem_addr_r  <= sel_addr_s;
            mem_wdata_r <= sel_wdata_s;
            mem_wen_r   <= sel_we_s;   // write enable lives only in ISSUE
          end
        end
        ST_ISSUE: begin
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          state_r  <= ST_IDLE;
          busy_r   <= 1'b0;
          last_b_r <= gnt_b_r;
          if (gnt_b_r) begin
            b_ack_r <= 1'b1;
            if (!we_r) begin
              b_rdata_r <= mem_rdata;
            end
          end else begin
            a_ack_r <= 1'b1;
            if (!we_r) begin
              a_rdata_r <= mem_rdata;
            end
          end
          if (lock_r && (lock_cnt_r < LOCK_LIM)) begin
            owner_r    <= gnt_b_r ? OWN_B : OWN_A;
            lock_cnt_r <= lock_cnt_r + 4'd1;
          end else begin
            owner_r    <= OWN_NONE;
            lock_cnt_r <= 4'd0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] a_grant_cnt_r;
  logic [15:0] b_grant_cnt_r;

  // Saturating per-port completed-transaction counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_grant_cnt_r <= 16'd0;
      b_grant_cnt_r <= 16'd0;
    end else if (state_r == ST_DONE) begin
      if (!gnt_b_r && (a_grant_cnt_r != 16'hFFFF)) begin
        a_grant_cnt_r <= a_grant_cnt_r + 16'd1;
      end
      if (gnt_b_r && (b_grant_cnt_r != 16'hFFFF)) begin
        b_grant_cnt_r <= b_grant_cnt_r + 16'd1;
      end
    end
  end

  assign a_grant_cnt = a_grant_cnt_r;
  assign b_grant_cnt = b_grant_cnt_r;
`endif

  assign a_ack     = a_ack_r;
  assign b_ack     = b_ack_r;
  assign a_rdata   = a_rdata_r;
  assign b_rdata   = b_rdata_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_wen   = mem_wen_r;
  assign busy      = busy_r;
  assign mem_rst   = ~reset;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
// Testbench for mem_bus_arbiter: two randomized requesters, a registered-read
// BRAM, a transaction-level reference model feeding a scoreboard queue, and
// an independent monitor that checks acks, read data, write enable and busy.
module tb_mem_bus_arbiter;

  localparam int MAXC = 20000;

  logic        clk;
  logic        reset;
  logic [1:0]  req_v;
  logic [1:0]  we_v;
  logic [1:0]  lock_v;
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic        a_ack, b_ack;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wen, mem_rst, busy;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .a_req(req_v[0]), .a_we(we_v[0]), .a_lock(lock_v[0]),
    .a_addr(addr_v[0]), .a_wdata(wdata_v[0]), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(req_v[1]), .b_we(we_v[1]), .b_lock(lock_v[1]),
    .b_addr(addr_v[1]), .b_wdata(wdata_v[1]), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_rst(mem_rst), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit model_en = 1'b0;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  bit          exp_wen  [MAXC];
  bit          exp_busy [MAXC];
  logic [31:0] exp_addr [MAXC];

  function automatic logic [31:0] init_val(int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  function automatic int cyc_now();
    return int'($time / 64'd10);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Registered-read BRAM, 16 words, with unwritten words at a known pattern.
  logic [31:0] bram    [16];
  bit          written [16];
  always @(posedge clk) begin
    if (mem_wen) begin
      bram[mem_addr[3:0]]    <= mem_wdata;
      written[mem_addr[3:0]] <= 1'b1;
    end
    mem_rdata <= written[mem_addr[3:0]] ? bram[mem_addr[3:0]] : init_val(int'(mem_addr[3:0]));
  end

  // Reference model: one transaction per 3 cycles, decided whenever the bus is free.
  initial begin : model
    logic [31:0] refmem  [16];
    logic [31:0] rd_hold [2];
    int next_free, last, owner, streak, w, c;
    for (int i = 0; i < 16; i++) refmem[i] = init_val(i);
    rd_hold[0] = 32'd0; rd_hold[1] = 32'd0;
    next_free = 0; last = 1; owner = -1; streak = 0;
    forever begin
      @(posedge clk);
      c = cyc_now();
      if (model_en && c >= next_free && c + 2 < MAXC) begin
        if (owner >= 0 && !req_v[owner]) begin
          owner = -1; streak = 0;
        end
        if (req_v != 2'b00) begin
          if (owner >= 0) w = owner;
          else if (req_v == 2'b11) w = 1 - last;
          else w = req_v[0] ? 0 : 1;
          if (we_v[w]) refmem[addr_v[w][3:0]] = wdata_v[w];
          else rd_hold[w] = refmem[addr_v[w][3:0]];
          sb.push_back('{port: w, rdata: rd_hold[w], cyc: c + 2});
          exp_wen[c]  = we_v[w];
          exp_addr[c] = addr_v[w];
          exp_busy[c] = 1'b1;
          exp_busy[c + 1] = 1'b1;
          last = w;
          if (lock_v[w]) begin
            streak = (owner == w) ? streak + 1 : 1;
            if (streak < 4) owner = w;
            else begin owner = -1; streak = 0; end
          end else begin
            owner = -1; streak = 0;
          end
          next_free = c + 3;
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard one cycle at a time.
  initial begin : monitor
    exp_t e;
    int   c, p;
    forever begin
      @(posedge clk); #1;
      c = cyc_now();
      if (model_en && c < MAXC) begin
        chk("mem_wen", 64'(mem_wen), 64'(exp_wen[c]));
        chk("busy", 64'(busy), 64'(exp_busy[c]));
        if (exp_wen[c]) chk("wr_addr", 64'(mem_addr), 64'(exp_addr[c]));
        if (a_ack && b_ack) chk("ack_overlap", 64'(2'b11), 64'(2'b01));
        if (a_ack || b_ack) begin
          p = b_ack ? 1 : 0;
          if (sb.size() == 0) begin
            chk("unexpected_ack", 64'(p + 1), 64'd0);
          end else begin
            e = sb.pop_front();
            chk("ack_port", 64'(p), 64'(e.port));
            chk("ack_cycle", 64'(c), 64'(e.cyc));
            chk("rdata", 64'(p ? b_rdata : a_rdata), 64'(e.rdata));
          end
        end else if (sb.size() > 0 && sb[0].cyc < c) begin
          e = sb.pop_front();
          chk("missing_ack", 64'd0, 64'(e.port + 1));
        end
      end
    end
  end

  // One requester: random transactions, holding fields until ack, bounded wait.
  task automatic run_port(int p, int n, int lock_pct, int gap_max, int we_pct);
    int gap, waited;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(gap_max, 0);
      if (gap > 0) begin
        req_v[p] = 1'b0;
        repeat (gap) @(posedge clk);
        #2;
      end
      we_v[p]    = ($urandom_range(99, 0) < we_pct);
      lock_v[p]  = ($urandom_range(99, 0) < lock_pct);
      addr_v[p]  = 32'($urandom_range(15, 0));
      wdata_v[p] = $urandom;
      req_v[p]   = 1'b1;
      waited = 0;
      do begin
        @(posedge clk); #2;
        waited++;
      end while (!(p ? b_ack : a_ack) && waited < 200);
      if (waited >= 200) begin
        chk("ack_timeout", 64'(p), 64'(p + 10));
        i = n;
      end
    end
    req_v[p]  = 1'b0;
    lock_v[p] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 60) begin
      @(posedge clk); n++;
    end
    if (sb.size() > 0) chk("drain", 64'(sb.size()), 64'd0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0; req_v = 2'b00; we_v = 2'b00; lock_v = 2'b00;
    addr_v[0] = 32'd0; addr_v[1] = 32'd0; wdata_v[0] = 32'd0; wdata_v[1] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_rst", 64'(mem_rst), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wen", 64'(mem_wen), 64'd0);
    chk("rst_acks", 64'({a_ack, b_ack}), 64'd0);
    chk("rst_rdata", 64'({a_rdata, b_rdata}), 64'd0);
    chk("rst_bus", 64'({mem_addr, mem_wdata}), 64'd0);
    #1 reset = 1'b1;
    model_en = 1'b1;
    #1 chk("run_mem_rst", 64'(mem_rst), 64'd0);

    // Mixed traffic, occasional locks.
    fork
      run_port(0, 40, 30, 3, 50);
      run_port(1, 40, 30, 3, 50);
    join
    drain();
    // A locks continuously against a saturating B: runs of 4 A, then B.
    fork
      run_port(0, 24, 100, 0, 30);
      run_port(1, 8, 0, 0, 30);
    join
    drain();
    // Both lock and request back-to-back.
    fork
      run_port(0, 20, 100, 1, 50);
      run_port(1, 20, 100, 1, 50);
    join
    drain();
    // Plain round-robin saturation.
    fork
      run_port(0, 16, 0, 0, 50);
      run_port(1, 16, 0, 0, 50);
    join
    drain();

    // Asynchronous reset in the ISSUE cycle of a write.
    model_en = 1'b0;
    addr_v[0] = 32'd5; wdata_v[0] = 32'hCAFE_F00D; we_v[0] = 1'b1; lock_v[0] = 1'b0;
    req_v[0] = 1'b1;
    @(posedge clk);
    #5;
    chk("issue_wen", 64'(mem_wen), 64'd1);
    chk("issue_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("arst_wen", 64'(mem_wen), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_mem_rst", 64'(mem_rst), 64'd1);
    chk("arst_bus", 64'({mem_addr, mem_wdata}), 64'd0);
    chk("arst_rdata", 64'({a_rdata, b_rdata}), 64'd0);
    req_v[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("arst_no_ack", 64'({a_ack, b_ack}), 64'd0);
    end
    #1 reset = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst_idle", 64'({a_ack, b_ack, busy, mem_wen}), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
